// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmit port.
package uart_mmio_pkg;

    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DivWidth    = 16;
    localparam int unsigned DataBits    = 8;
    localparam int unsigned StopBits    = 1;
    localparam int unsigned BitIdxWidth = $clog2(DataBits);

    localparam logic [AddrWidth-1:0] OffTxData = 32'h0000_0000;
    localparam logic [AddrWidth-1:0] OffCtrl   = 32'h0000_0004;
    localparam logic [AddrWidth-1:0] OffStatus = 32'h0000_0008;

    localparam int unsigned StatEmptyBit   = 0;
    localparam int unsigned StatFullBit    = 1;
    localparam int unsigned StatBusyBit    = 2;
    localparam int unsigned StatOvfBit     = 3;
    localparam int unsigned StatCountLsb   = 4;
    localparam int unsigned StatCountWidth = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

endpackage

// File: rtl/uart_mmio_tx_fifo.sv
// Synchronous FIFO; a push is accepted while full when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign count   = wrPtr - rdPtr;
    assign empty   = (wrPtr == rdPtr);
    assign full    = (count == PtrW'(DEPTH));
    assign popData = mem[rdPtr[AddrW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PtrW'(1);
            if (doPop)  rdPtr <= rdPtr + PtrW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AddrW-1:0]] <= pushData;
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// Store-snooping UART transmitter: TXDATA/CTRL writes, STATUS reads, 8N1 serializer.
module uart_mmio_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [AddrWidth-1:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [DivWidth-1:0]  DIV_RESET  = 16'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    input  logic [AddrWidth-1:0] DataAdr,
    input  logic [31:0]          WriteData,
    output logic [31:0]          mmio_rdata,
    output logic                 mmio_hit,
    output logic                 tx
);

    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    txState_t                 state, stateNext;
    logic [DataBits-1:0]      shift, shiftNext;
    logic [DivWidth-1:0]      baudCnt, baudNext;
    logic [DivWidth-1:0]      divAct, divActNext;
    logic [DivWidth-1:0]      div;
    logic [BitIdxWidth-1:0]   bitIdx, bitIdxNext;
    logic                     txNext;
    logic                     ovf;
    logic                     bitEnd;

    logic                     txWr;
    logic                     ctrlWr;
    logic                     fifoPop;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [DataBits-1:0]      fifoData;
    logic [CountW-1:0]        fifoCount;
    logic                     unusedWriteHi;

    assign txWr          = MemWrite && (DataAdr == BASE_ADDR + OffTxData);
    assign ctrlWr        = MemWrite && (DataAdr == BASE_ADDR + OffCtrl);
    assign mmio_hit      = MemRead  && (DataAdr == BASE_ADDR + OffStatus);
    assign unusedWriteHi = ^WriteData[31:DivWidth];

    sync_fifo #(
        .WIDTH (DataBits),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (txWr),
        .pop      (fifoPop),
        .pushData (WriteData[DataBits-1:0]),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_comb begin
        mmio_rdata                                 = '0;
        mmio_rdata[StatEmptyBit]                   = fifoEmpty;
        mmio_rdata[StatFullBit]                    = fifoFull;
        mmio_rdata[StatBusyBit]                    = (state != IDLE);
        mmio_rdata[StatOvfBit]                     = ovf;
        mmio_rdata[StatCountLsb +: StatCountWidth] = StatCountWidth'(fifoCount);
    end

    // Divisor and sticky overflow; a CTRL write wins over a dropped push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= DIV_RESET;
            ovf <= 1'b0;
        end else if (ctrlWr) begin
            div <= (WriteData[DivWidth-1:0] == '0) ? DivWidth'(1) : WriteData[DivWidth-1:0];
            ovf <= 1'b0;
        end else if (txWr && fifoFull && !fifoPop) begin
            ovf <= 1'b1;
        end
    end

    assign bitEnd = (baudCnt == divAct - DivWidth'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= '0;
            baudCnt <= '0;
            divAct  <= DIV_RESET;
            bitIdx  <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= stateNext;
            shift   <= shiftNext;
            baudCnt <= baudNext;
            divAct  <= divActNext;
            bitIdx  <= bitIdxNext;
            tx      <= txNext;
        end
    end

    // Frame sequencer; a new frame is loaded from IDLE or directly from the end of STOP.
    always_comb begin
        stateNext  = state;
        shiftNext  = shift;
        baudNext   = baudCnt;
        divActNext = divAct;
        bitIdxNext = bitIdx;
        fifoPop    = 1'b0;

        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    shiftNext  = fifoData;
                    divActNext = div;
                    baudNext   = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudNext   = '0;
                    bitIdxNext = '0;
                    stateNext  = DATA;
                end else begin
                    baudNext = baudCnt + DivWidth'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    shiftNext = {1'b0, shift[DataBits-1:1]};
                    if (bitIdx == BitIdxWidth'(DataBits - 1)) begin
                        bitIdxNext = '0;
                        stateNext  = STOP;
                    end else begin
                        bitIdxNext = bitIdx + BitIdxWidth'(1);
                    end
                end else begin
                    baudNext = baudCnt + DivWidth'(1);
                end
            end
            STOP: begin
                if (bitEnd) begin
                    baudNext = '0;
                    if (bitIdx != BitIdxWidth'(StopBits - 1)) begin
                        bitIdxNext = bitIdx + BitIdxWidth'(1);
                    end else if (!fifoEmpty) begin
                        fifoPop    = 1'b1;
                        shiftNext  = fifoData;
                        divActNext = div;
                        bitIdxNext = '0;
                        stateNext  = START;
                    end else begin
                        bitIdxNext = '0;
                        stateNext  = IDLE;
                    end
                end else begin
                    baudNext = baudCnt + DivWidth'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        txNext = 1'b1;
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            default: txNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Randomized and directed checks of uart_mmio_tx against a frame-level reference model.
module tb_uart_mmio_tx;

    localparam logic [31:0] BASE   = 32'h0000_FF00;
    localparam int          DEPTH  = 4;
    localparam int          DIVRST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] mmio_rdata;
    logic        mmio_hit;
    logic        tx;

    uart_mmio_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'(DIVRST))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .mmio_rdata (mmio_rdata),
        .mmio_hit   (mmio_hit),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue plus the frame currently on the wire.
    logic [7:0]  q[$];
    int          divReg = DIVRST;
    int          divAct = DIVRST;
    int          t = 0;
    bit          active = 0;
    bit          ovf = 0;
    logic [9:0]  frame = '1;
    logic        expTx = 1'b1;
    logic [31:0] expStatus = 32'h1;
    logic        expHit = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic tick(input logic r, input logic we, input logic re,
                        input logic [31:0] adr, input logic [31:0] wd);
        logic [7:0] b;
        rst = r; MemWrite = we; MemRead = re; DataAdr = adr; WriteData = wd;
        @(posedge clk);
        if (!r) begin
            q.delete();
            divReg = DIVRST; active = 0; t = 0; ovf = 0;
        end else begin
            if (active) begin
                t++;
                if (t == 10 * divAct) active = 0;
            end
            if (!active && q.size() != 0) begin
                b = q.pop_front();
                frame = {1'b1, b, 1'b0};
                t = 0; divAct = divReg; active = 1;
            end
            if (we && adr == BASE) begin
                if (q.size() < DEPTH) q.push_back(wd[7:0]);
                else ovf = 1;
            end
            if (we && adr == BASE + 32'd4) begin
                divReg = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
                ovf = 0;
            end
        end
        expTx = active ? frame[t / divAct] : 1'b1;
        expStatus = {24'd0, 4'(q.size()), ovf, active, q.size() == DEPTH, q.size() == 0};
        expHit = re && (adr == BASE + 32'd8);
        #1;
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b want=1", tx); end
        tests++; if (mmio_rdata !== 32'h1) begin fails++; $display("FAIL reset_status got=%h want=00000001", mmio_rdata); end
        tests++; if (mmio_hit !== 1'b0) begin fails++; $display("FAIL reset_hit got=%b want=0", mmio_hit); end
        tick(1'b1, 1'b0, 1'b1, BASE + 32'd8, 32'h0);
        tests++; if (mmio_hit !== 1'b1) begin fails++; $display("FAIL status_hit got=%b want=1", mmio_hit); end
        tests++; if (mmio_rdata !== 32'h1) begin fails++; $display("FAIL status_read got=%h want=00000001", mmio_rdata); end
        tick(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'h0);
        tests++; if (mmio_hit !== 1'b0) begin fails++; $display("FAIL ctrl_no_hit got=%b want=0", mmio_hit); end
    endtask

    task automatic test_single_byte();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_0055);
        tests++; if (mmio_rdata !== 32'h10) begin fails++; $display("FAIL single_queued got=%h want=00000010", mmio_rdata); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_nobypass got=%b want=1", tx); end
        for (int i = 0; i < 40; i++) begin
            idle();
            tests++;
            if (tx !== 1'((i / 4) % 2) || tx !== expTx) begin
                fails++; $display("FAIL single_bit cyc=%0d got=%b want=%b", i, tx, 1'((i / 4) % 2));
            end
        end
        idle();
        tests++; if (mmio_rdata !== 32'h1 || tx !== 1'b1) begin
            fails++; $display("FAIL single_done status=%h tx=%b want=00000001/1", mmio_rdata, tx);
        end
    endtask

    task automatic test_divisor();
        int busy;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'hFFFF_0000);
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_00A5);
        busy = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) tick(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'h0000_0008);
            else idle();
            if (mmio_rdata[2]) busy++;
            tests++; if (tx !== expTx) begin fails++; $display("FAIL div1_bit cyc=%0d got=%b want=%b", i, tx, expTx); end
        end
        tests++; if (busy !== 10) begin fails++; $display("FAIL div1_len got=%0d want=10", busy); end
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_003C);
        busy = 0;
        for (int i = 0; i < 84; i++) begin
            idle();
            if (mmio_rdata[2]) busy++;
            tests++; if (tx !== expTx) begin fails++; $display("FAIL div8_bit cyc=%0d got=%b want=%b", i, tx, expTx); end
        end
        tests++; if (busy !== 80) begin fails++; $display("FAIL div8_len got=%0d want=80", busy); end
    endtask

    task automatic test_overflow();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'b0, BASE, 32'(8'h11 * (k + 1)));
        tests++; if (mmio_rdata !== 32'h4E || mmio_rdata !== expStatus) begin
            fails++; $display("FAIL ovf_status got=%h want=0000004e", mmio_rdata);
        end
        tick(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'h0000_0004);
        tests++; if (mmio_rdata[3] !== 1'b0 || mmio_rdata !== expStatus) begin
            fails++; $display("FAIL ovf_clear got=%h want=%h", mmio_rdata, expStatus);
        end
        for (int i = 0; i < 220; i++) begin
            idle();
            tests++; if (tx !== expTx) begin fails++; $display("FAIL ovf_drain cyc=%0d got=%b want=%b", i, tx, expTx); end
        end
        tests++; if (mmio_rdata !== 32'h1) begin fails++; $display("FAIL ovf_empty got=%h want=00000001", mmio_rdata); end
    endtask

    task automatic test_back_to_back();
        logic txLog [84];
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_0001);
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_0080);
        txLog[0] = tx;
        for (int j = 1; j < 84; j++) begin
            idle();
            txLog[j] = tx;
            tests++; if (tx !== expTx) begin fails++; $display("FAIL b2b_bit cyc=%0d got=%b want=%b", j, tx, expTx); end
        end
        tests++; if (txLog[35] !== 1'b0 || txLog[36] !== 1'b1 || txLog[39] !== 1'b1) begin
            fails++; $display("FAIL b2b_stop got=%b%b%b want=011", txLog[35], txLog[36], txLog[39]);
        end
        tests++; if (txLog[40] !== 1'b0 || txLog[43] !== 1'b0) begin
            fails++; $display("FAIL b2b_start got=%b%b want=00", txLog[40], txLog[43]);
        end
    endtask

    task automatic test_reset_midframe();
        int busy;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'h0000_0003);
        tick(1'b1, 1'b1, 1'b0, BASE, 32'($urandom_range(0, 255)));
        for (int j = 0; j < 13; j++) idle();
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midrst_tx got=%b want=1", tx); end
        tests++; if (mmio_rdata !== 32'h1) begin fails++; $display("FAIL midrst_status got=%h want=00000001", mmio_rdata); end
        for (int j = 0; j < 30; j++) begin
            idle();
            tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midrst_residual cyc=%0d got=%b want=1", j, tx); end
        end
        tick(1'b1, 1'b1, 1'b0, BASE, 32'h0000_00C3);
        busy = 0;
        for (int i = 0; i < 44; i++) begin
            idle();
            if (mmio_rdata[2]) busy++;
            tests++; if (tx !== expTx) begin fails++; $display("FAIL midrst_frame cyc=%0d got=%b want=%b", i, tx, expTx); end
        end
        tests++; if (busy !== 10 * DIVRST) begin fails++; $display("FAIL midrst_div got=%0d want=%0d", busy, 10 * DIVRST); end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] adr;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 99);
            if (op < 1) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            else if (op < 16) tick(1'b1, 1'b1, $urandom_range(0, 1) == 1, BASE, $urandom);
            else if (op < 21) tick(1'b1, 1'b1, 1'b0, BASE + 32'd4,
                                   {$urandom_range(0, 65535) == 0 ? 16'h0 : 16'($urandom), 16'($urandom_range(0, 4))});
            else if (op < 31) tick(1'b1, 1'b0, 1'b1, BASE + 32'd8, $urandom);
            else if (op < 37) begin
                case ($urandom_range(0, 3))
                    0: adr = BASE + 32'd1;
                    1: adr = BASE + 32'd8;
                    2: adr = BASE + 32'd12;
                    default: adr = BASE ^ 32'h0001_0000;
                endcase
                tick(1'b1, 1'b1, $urandom_range(0, 1) == 1, adr, $urandom);
            end
            else idle();
            tests++; if (tx !== expTx) begin fails++; $display("FAIL rand_tx cyc=%0d got=%b want=%b", i, tx, expTx); end
            tests++; if (mmio_rdata !== expStatus) begin fails++; $display("FAIL rand_status cyc=%0d got=%h want=%h", i, mmio_rdata, expStatus); end
            tests++; if (mmio_hit !== expHit) begin fails++; $display("FAIL rand_hit cyc=%0d got=%b want=%b", i, mmio_hit, expHit); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_divisor();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
